// File: rtl/pwd_rom_arb_pkg.sv
// Shared constants and state encoding for the password-ROM fetch arbiter.
// The ERR state only exists when PWD_ROM_BOUND_CHECK_EN is defined.
package pwd_rom_arb_pkg;

   localparam int ADDR_W  = 5;
   localparam int DATA_W  = 4;
   localparam int NIBBLES = 4;
   localparam int ROM_LAT = 2;
   localparam int RES_W   = NIBBLES * DATA_W;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_CAPTURE,
      S_DONE
`ifdef PWD_ROM_BOUND_CHECK_EN
      ,S_ERR
`endif
   } state_t;

endpackage

// File: rtl/pwd_rom_arbiter_if.sv
// Request/grant and ROM bus bundle between the requesters and pwd_rom_arbiter.
// The err pulse is only present when PWD_ROM_BOUND_CHECK_EN is defined.
interface pwd_rom_arbiter_if;
   import pwd_rom_arb_pkg::*;

   logic [1:0]          req;
   logic [2*ADDR_W-1:0] base_addr;
   logic [1:0]          gnt;
   logic [1:0]          done;
`ifdef PWD_ROM_BOUND_CHECK_EN
   logic [1:0]          err;
`endif
   logic [RES_W-1:0]    rd_data;
   logic                busy;
   logic [ADDR_W-1:0]   rom_addr;
   logic [DATA_W-1:0]   rom_data;

   modport slave (
      input  req, base_addr, rom_data,
      output gnt, done, rd_data, busy, rom_addr
`ifdef PWD_ROM_BOUND_CHECK_EN
      , err
`endif
   );

   modport master (
      output req, base_addr, rom_data,
      input  gnt, done, rd_data, busy, rom_addr
`ifdef PWD_ROM_BOUND_CHECK_EN
      , err
`endif
   );

endinterface

// File: rtl/rr_arbiter2.sv
// Two-input round-robin pick; the pointer flips away from the last serviced
// requester whenever upd is strobed.
module rr_arbiter2 (
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] req,
   input  logic       upd,
   input  logic       upd_idx,
   output logic       pick,
   output logic       valid
);

   logic ptr;

   always_comb begin
      valid = |req;
      case (req)
         2'b01:   pick = 1'b0;
         2'b10:   pick = 1'b1;
         2'b11:   pick = ptr;
         default: pick = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset)
         ptr <= 1'b0;
      else if (upd)
         ptr <= ~upd_idx;
   end

endmodule

// File: rtl/pwd_rom_arbiter.sv
// Round-robin fetch sequencer for the shared 2-cycle-latency password ROM.
// Define PWD_ROM_BOUND_CHECK_EN to reject bases whose fetch would run past the top of the ROM.
module pwd_rom_arbiter
   import pwd_rom_arb_pkg::*;
(
   input logic              clk,
   input logic              reset,
   pwd_rom_arbiter_if.slave bus
);

   localparam int IDX_W  = $clog2(NIBBLES);
   localparam int WCNT_W = $clog2(ROM_LAT + 1);
   localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NIBBLES - 1);
   localparam logic [WCNT_W-1:0] WAIT_LAST = WCNT_W'(ROM_LAT - 1);

   state_t              state;
   logic                gidx;
   logic [ADDR_W-1:0]   base_q;
   logic [IDX_W-1:0]    word_idx;
   logic [WCNT_W-1:0]   wait_cnt;
   logic [RES_W-1:0]    shadow;
   logic [RES_W-1:0]    shadow_next;
   logic                pick;
   logic                pick_valid;
   logic                ptr_upd;
   logic [1:0]          pick_onehot;
   logic [1:0]          gidx_onehot;
   logic [ADDR_W-1:0]   win_base;

   assign pick_onehot = {pick, ~pick};
   assign gidx_onehot = {gidx, ~gidx};
   assign win_base    = pick ? bus.base_addr[ADDR_W +: ADDR_W] : bus.base_addr[0 +: ADDR_W];

`ifdef PWD_ROM_BOUND_CHECK_EN
   localparam logic [ADDR_W:0] MAX_BASE = (ADDR_W + 1)'((1 << ADDR_W) - NIBBLES);
   logic win_out_of_range;
   assign win_out_of_range = ({1'b0, win_base} > MAX_BASE);
   assign ptr_upd = (state == S_DONE) || (state == S_ERR);
`else
   assign ptr_upd = (state == S_DONE);
`endif

   rr_arbiter2 u_rr (
      .clk     (clk),
      .reset   (reset),
      .req     (bus.req),
      .upd     (ptr_upd),
      .upd_idx (gidx),
      .pick    (pick),
      .valid   (pick_valid)
   );

   // Word 0 lands in the MSBs so the packed result reads in fetch order.
   always_comb begin
      shadow_next = shadow;
      shadow_next[(NIBBLES - 1 - int'(word_idx)) * DATA_W +: DATA_W] = bus.rom_data;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= S_IDLE;
         gidx         <= 1'b0;
         base_q       <= '0;
         word_idx     <= '0;
         wait_cnt     <= '0;
         shadow       <= '0;
         bus.gnt      <= '0;
         bus.done     <= '0;
`ifdef PWD_ROM_BOUND_CHECK_EN
         bus.err      <= '0;
`endif
         bus.busy     <= 1'b0;
         bus.rd_data  <= '0;
         bus.rom_addr <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (pick_valid) begin
                  gidx     <= pick;
                  base_q   <= win_base;
                  word_idx <= '0;
                  bus.gnt  <= pick_onehot;
                  bus.busy <= 1'b1;
`ifdef PWD_ROM_BOUND_CHECK_EN
                  if (win_out_of_range) begin
                     bus.err <= pick_onehot;
                     state   <= S_ERR;
                  end else begin
                     state   <= S_ISSUE;
                  end
`else
                  state <= S_ISSUE;
`endif
               end
            end
            S_ISSUE: begin
               bus.rom_addr <= base_q + ADDR_W'(word_idx);
               wait_cnt     <= '0;
               state        <= S_WAIT;
            end
            S_WAIT: begin
               if (wait_cnt == WAIT_LAST)
                  state <= S_CAPTURE;
               else
                  wait_cnt <= wait_cnt + 1'b1;
            end
            S_CAPTURE: begin
               shadow <= shadow_next;
               if (word_idx == IDX_LAST) begin
                  bus.rd_data <= shadow_next;
                  bus.done    <= gidx_onehot;
                  state       <= S_DONE;
               end else begin
                  word_idx <= word_idx + 1'b1;
                  state    <= S_ISSUE;
               end
            end
            S_DONE: begin
               bus.done <= '0;
               bus.gnt  <= '0;
               bus.busy <= 1'b0;
               state    <= S_IDLE;
            end
`ifdef PWD_ROM_BOUND_CHECK_EN
            S_ERR: begin
               bus.err  <= '0;
               bus.gnt  <= '0;
               bus.busy <= 1'b0;
               state    <= S_IDLE;
            end
`endif
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_pwd_rom_arbiter.sv
// Directed bench for pwd_rom_arbiter with a 2-cycle synchronous ROM model.
// Boundary checks follow PWD_ROM_BOUND_CHECK_EN.
module tb_pwd_rom_arbiter;
   import pwd_rom_arb_pkg::*;

   logic clk = 1'b0;
   logic reset;

   always #5 clk = ~clk;

   pwd_rom_arbiter_if bus();

   pwd_rom_arbiter dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   int checkCount = 0;
   int errorCount = 0;
   logic [RES_W-1:0]  lastWord = '0;
   logic [ADDR_W-1:0] lastAddr = '0;
   logic [ADDR_W-1:0] romAddrQ;

   // ROM contents: word i = i mod 16, except words 8..11 = 1,2,3,4.
   function automatic logic [DATA_W-1:0] romWord(input logic [ADDR_W-1:0] a);
      if (a >= 5'd8 && a <= 5'd11)
         return DATA_W'(a - 5'd7);
      else
         return a[3:0];
   endfunction

   always @(posedge clk) begin
      romAddrQ     <= bus.rom_addr;
      bus.rom_data <= romWord(romAddrQ);
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: observed %0h expected %0h at %0t", tag, observed, expected, $time);
      end
   endtask

   task automatic applyStimulus(input logic [1:0] reqV, input logic [ADDR_W-1:0] base0, input logic [ADDR_W-1:0] base1);
      bus.req       = reqV;
      bus.base_addr = {base1, base0};
   endtask

   task automatic checkIdleOutputs(input string tag);
      checkOutput({tag, "_gnt"}, 32'(bus.gnt), 32'd0);
      checkOutput({tag, "_done"}, 32'(bus.done), 32'd0);
      checkOutput({tag, "_busy"}, 32'(bus.busy), 32'd0);
      checkOutput({tag, "_rd_data"}, 32'(bus.rd_data), 32'(lastWord));
      checkOutput({tag, "_rom_addr"}, 32'(bus.rom_addr), 32'(lastAddr));
`ifdef PWD_ROM_BOUND_CHECK_EN
      checkOutput({tag, "_err"}, 32'(bus.err), 32'd0);
`endif
   endtask

   // One full fetch, called while the DUT is in IDLE; returns in the IDLE cycle after DONE.
   task automatic runOp(input int idx, input logic [ADDR_W-1:0] base, input logic [RES_W-1:0] expWord,
                        input bit dropReq, input bit reRaise);
      logic [1:0] oneHot;
      logic [ADDR_W-1:0] expAddr;
      oneHot = 2'b01 << idx;
      bus.req[idx] = 1'b1;
      bus.base_addr[idx*ADDR_W +: ADDR_W] = base;
      for (int c = 1; c <= 17; c++) begin
         @(posedge clk); #1;
         checkOutput("gnt", 32'(bus.gnt), 32'(oneHot));
         checkOutput("busy", 32'(bus.busy), 32'd1);
         if (c == 1) begin
            checkOutput("rom_addr_hold", 32'(bus.rom_addr), 32'(lastAddr));
            if (dropReq) bus.req[idx] = 1'b0;
         end
         if (c >= 2 && ((c - 2) % 4) == 0) begin
            expAddr = base + ADDR_W'((c - 2) / 4);
            checkOutput("rom_addr", 32'(bus.rom_addr), 32'(expAddr));
         end
         if (c < 17) begin
            checkOutput("done_early", 32'(bus.done), 32'd0);
            checkOutput("rd_data_held", 32'(bus.rd_data), 32'(lastWord));
         end else begin
            checkOutput("done", 32'(bus.done), 32'(oneHot));
            checkOutput("rd_data", 32'(bus.rd_data), 32'(expWord));
         end
`ifdef PWD_ROM_BOUND_CHECK_EN
         checkOutput("err_quiet", 32'(bus.err), 32'd0);
`endif
      end
      if (!dropReq) bus.req[idx] = 1'b0;
      lastWord = expWord;
      lastAddr = base + ADDR_W'(NIBBLES - 1);
      @(posedge clk); #1;
      checkIdleOutputs("post_done");
      if (reRaise) bus.req[idx] = 1'b1;
   endtask

`ifdef PWD_ROM_BOUND_CHECK_EN
   task automatic errOp(input int idx, input logic [ADDR_W-1:0] base);
      logic [1:0] oneHot;
      oneHot = 2'b01 << idx;
      bus.req[idx] = 1'b1;
      bus.base_addr[idx*ADDR_W +: ADDR_W] = base;
      @(posedge clk); #1;
      checkOutput("err_pulse", 32'(bus.err), 32'(oneHot));
      checkOutput("err_gnt", 32'(bus.gnt), 32'(oneHot));
      checkOutput("err_busy", 32'(bus.busy), 32'd1);
      checkOutput("err_done", 32'(bus.done), 32'd0);
      checkOutput("err_rom_addr", 32'(bus.rom_addr), 32'(lastAddr));
      checkOutput("err_rd_data", 32'(bus.rd_data), 32'(lastWord));
      bus.req[idx] = 1'b0;
      @(posedge clk); #1;
      checkIdleOutputs("post_err");
   endtask
`endif

   initial begin
      bit sawDone;
      reset = 1'b1;
      applyStimulus(2'b00, 5'd0, 5'd0);
      repeat (3) @(posedge clk);
      #1;
      checkIdleOutputs("reset");
      reset = 1'b0;

      $display("[TB] single request, base 8");
      runOp(0, 5'd8, 16'h1234, 1'b0, 1'b0);

      $display("[TB] simultaneous requests after reset");
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      lastWord = '0;
      lastAddr = '0;
      checkIdleOutputs("reset2");
      applyStimulus(2'b11, 5'd0, 5'd4);
      runOp(0, 5'd0, 16'h0123, 1'b0, 1'b0);
      runOp(1, 5'd4, 16'h4567, 1'b0, 1'b0);

      $display("[TB] round-robin fairness");
      applyStimulus(2'b11, 5'd12, 5'd20);
      runOp(0, 5'd12, 16'hCDEF, 1'b0, 1'b1);
      runOp(1, 5'd20, 16'h4567, 1'b0, 1'b1);
      runOp(0, 5'd12, 16'hCDEF, 1'b0, 1'b1);
      runOp(1, 5'd20, 16'h4567, 1'b0, 1'b0);
      bus.req = 2'b00;

      $display("[TB] reset during WAIT of word 2");
      applyStimulus(2'b01, 5'd12, 5'd20);
      for (int c = 1; c <= 10; c++) begin
         @(posedge clk); #1;
         if (c == 1) checkOutput("mid_gnt", 32'(bus.gnt), 32'd1);
      end
      reset = 1'b1;
      @(posedge clk); #1;
      lastWord = '0;
      lastAddr = '0;
      checkIdleOutputs("mid_reset");
      reset = 1'b0;
      bus.req = 2'b00;
      sawDone = 1'b0;
      for (int c = 0; c < 20; c++) begin
         @(posedge clk); #1;
         if (bus.done != 2'b00) sawDone = 1'b1;
      end
      checkOutput("no_done_after_reset", 32'(sawDone), 32'd0);

      $display("[TB] requester 1 drops req after grant");
      runOp(1, 5'd8, 16'h1234, 1'b1, 1'b0);

`ifdef PWD_ROM_BOUND_CHECK_EN
      $display("[TB] boundary bases with bound check");
      errOp(0, 5'd30);
      errOp(1, 5'd29);
      runOp(0, 5'd28, 16'hCDEF, 1'b0, 1'b0);
`else
      $display("[TB] boundary base wraps");
      runOp(0, 5'd30, 16'hEF01, 1'b0, 1'b0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
      $finish;
   end

endmodule

// File: doc/pwd_rom_arbiter.md
# pwd_rom_arbiter

Round-robin arbiter and fetch sequencer for the shared password ROM (synchronous ROM, 2-cycle read latency). Two requesters, such as the user-ID checker and the password checker, each post a base address. The block grants one requester at a time, reads `NIBBLES` consecutive ROM words, and returns them packed MSB-first. It sits between the authentication controllers and the single ROM instance, and owns the ROM address bus exclusively.

## Interface
- `ADDR_W`, 5, ROM address width
- `DATA_W`, 4, ROM word width
- `NIBBLES`, 4, words fetched per request; result width `RES_W = NIBBLES*DATA_W`
- `ROM_LAT`, 2, idle cycles between address issue and capture
- `clk`  in  1  single clock, all state updates on rising edge
- `reset`  in  1  synchronous, active-high reset
- `req`  in  2  per-requester request level; held until `done` or `err` for that requester
- `base_addr`  in  2*ADDR_W  requester i base address at bits [i*ADDR_W +: ADDR_W]
- `gnt`  out  2  one-hot grant, high for the whole serviced operation
- `done`  out  2  one-cycle completion pulse to the granted requester
- `err`  out  2  one-cycle range-error pulse (present only with `PWD_ROM_BOUND_CHECK_EN`)
- `rd_data`  out  RES_W  packed result, word 0 in MSBs; valid while `done` is high and held afterwards
- `busy`  out  1  high in every non-IDLE state
- `rom_addr`  out  ADDR_W  registered ROM address
- `rom_data`  in  DATA_W  ROM read data

## Operation
- Reset values: `gnt` = 0, `done` = 0, `err` = 0, `busy` = 0, `rd_data` = 0, `rom_addr` = 0. State is IDLE and the round-robin pointer favours requester 0.
- States: IDLE, ISSUE, WAIT, CAPTURE, DONE, plus ERR (macro only).
- IDLE:
  - `req` is sampled only here.
  - If one requester is asserted, it wins. If both are asserted, the pointer decides.
  - The winner's `base_addr` is latched, `gnt` is set, and the state goes to ISSUE.
- ISSUE: `rom_addr` ← latched base plus word index k. Go to WAIT.
- WAIT: stays for exactly `ROM_LAT` cycles, counted by a wait counter, then goes to CAPTURE.
- CAPTURE:
  - `rom_data` is stored into result slot k, at bits [RES_W-1-k*DATA_W -: DATA_W].
  - If k < NIBBLES-1, k increments and the state goes to ISSUE. Otherwise the state goes to DONE.
- DONE:
  - `done[g]` = 1 for one cycle, where g is the granted requester.
  - `rd_data` is updated from the assembled result.
  - The pointer moves to the other requester, `gnt` clears on exit, and the state goes to IDLE.
- The result assembles in an internal shadow register. `rd_data` changes only on entry to DONE.
- Dropping `req` mid-operation has no effect: the fetch completes and `done` still pulses. There is no abort.
- A requester must deassert `req` in the cycle `done` or `err` is seen. A `req` still high in the following IDLE is treated as a new request.
- Reset mid-operation: the next edge returns to IDLE with all outputs at reset values. No `done` is generated.
- `rom_addr` holds its last value between operations.

## Timing
- Per word: `ROM_LAT+2` cycles (ISSUE, `ROM_LAT` WAIT cycles, CAPTURE).
- Grant latency: `gnt` is high the cycle after `req` is sampled in IDLE.
- Completion latency: `done` is high `NIBBLES*(ROM_LAT+2)+1` cycles after the sampling edge, i.e. 17 cycles with defaults.
- Minimum spacing between grants: one IDLE cycle after DONE.
- Back-to-back with both requesting: service alternates 0,1,0,1.

## Configuration
- Macro: `PWD_ROM_BOUND_CHECK_EN`.
- Defined:
  - In IDLE, a winner with base > 2^ADDR_W − NIBBLES goes to ERR instead of ISSUE.
  - ERR lasts one cycle: `err[g]` = 1 and `gnt[g]` = 1; the pointer advances, then the state returns to IDLE.
  - No ROM address is issued and `rd_data` is unchanged.
- Undefined:
  - The `err` port and ERR state are absent.
  - Addresses wrap modulo 2^ADDR_W, so base 30 reads 30, 31, 0, 1.

## Structure
- Package `pwd_rom_arb_pkg`: state enum, default `ADDR_W`/`DATA_W`/`NIBBLES`/`ROM_LAT` constants, `RES_W` derivation.
- One sub-module, `rr_arbiter2`: two-input round-robin pick with a pointer-update strobe. Sequencing, counters and packing stay in the top module.

## Test plan
- **Single request:** ROM[8..11] = 1,2,3,4; `req[0]` with base 8 → `gnt` = 01 the next cycle; `rom_addr` steps 8, 9, 10, 11; `done[0]` at cycle 17; `rd_data` = 16'h1234.
- **Simultaneous requests after reset:** `req` = 11, bases 0 and 4 → requester 0 served first, then requester 1 after one IDLE cycle; each `done` carries its own 16-bit word; `gnt` is never 11.
- **Round-robin fairness:** both requesters held high, re-raised on `done` → grants alternate 0,1,0,1 over 4 operations.
- **Mid-operation reset:** assert `reset` during the WAIT of word 2 → the next cycle shows all outputs at 0 and `busy` = 0; a new request completes normally with correct data.
- **Requester drops `req` mid-fetch:** `req[1]` deasserted after the grant → `done[1]` still pulses at cycle 17 with correct data.
- **Boundary address:** base 30 with the macro defined → `err` pulse the cycle after sampling, no `rom_addr` change, `rd_data` unchanged. Without the macro → reads 30, 31, 0, 1 and `done` pulses.
